// File: rtl/minimac2_tx_if.sv
// minimac2_tx_if: signal bundle between the minimac2 MII transmit engine and
// its surroundings (synchronized start/count/done handshake, TX packet
// buffer read port, MII transmit pins). Carries no clock or reset.
//
//   tx_start     single-cycle start request (phy_tx_clk domain)
//   tx_count     frame length in bytes, sampled with tx_start
//   tx_busy      high from accepted start until tx_done
//   tx_done      single-cycle completion pulse
//   txb_adr      TX buffer byte address
//   txb_dat      TX buffer read data, one cycle after txb_adr
//   phy_tx_en    MII TX_EN
//   phy_tx_er    MII TX_ER (always 0)
//   phy_tx_data  MII TXD nibble
//
// Modports: slave = transmit engine, master = control logic + buffer + PHY.
interface minimac2_tx_if;
    logic        tx_start;
    logic [10:0] tx_count;
    logic        tx_busy;
    logic        tx_done;
    logic [10:0] txb_adr;
    logic [7:0]  txb_dat;
    logic        phy_tx_en;
    logic        phy_tx_er;
    logic [3:0]  phy_tx_data;

    modport slave (
        input  tx_start, tx_count, txb_dat,
        output tx_busy, tx_done, txb_adr, phy_tx_en, phy_tx_er, phy_tx_data
    );

    modport master (
        output tx_start, tx_count, txb_dat,
        input  tx_busy, tx_done, txb_adr, phy_tx_en, phy_tx_er, phy_tx_data
    );
endinterface

// File: rtl/minimac2_tx.sv
// minimac2_tx: MII transmit engine of the minimac2 Ethernet MAC.
// Sends preamble (PREAMBLE_NIBBLES x 0x5) and SFD 0xD, then the frame bytes
// read from the TX buffer as nibbles (low nibble first), optionally the
// CRC-32 FCS, and finally holds TX_EN low for IFG_NIBBLES cycles before
// pulsing tx_done.
//
// Ports:
//   phy_tx_clk  MII transmit clock, sole clock
//   phy_rst_n   asynchronous active-low reset
//   bus         minimac2_tx_if.slave (handshake, buffer port, MII pins)
//
// Build option: define MINIMAC2_TX_CRC_EN to append a CRC-32 FCS
// (8 nibbles of ~crc, LSB nibble first). Without it, the FCS is expected to
// be part of the buffer contents.
module minimac2_tx #(
    parameter int unsigned PREAMBLE_NIBBLES = 15,
    parameter int unsigned IFG_NIBBLES      = 24
) (
    input  logic          phy_tx_clk,
    input  logic          phy_rst_n,
    minimac2_tx_if.slave  bus
);

`ifdef MINIMAC2_TX_CRC_EN
    typedef enum logic [2:0] {
        S_IDLE, S_PREAMBLE, S_DATA_LO, S_DATA_HI, S_FCS, S_IFG
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_PREAMBLE, S_DATA_LO, S_DATA_HI, S_IFG
    } state_t;
`endif

    localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_NIBBLES);
    localparam logic [15:0] IFG_LAST = 16'(IFG_NIBBLES);

    state_t      state_q;
    logic [15:0] cnt_q;     // preamble / FCS / IFG cycle counter
    logic [10:0] rem_q;     // bytes still to send, including current
    logic [3:0]  hi_q;      // high nibble of the byte being sent
    logic [10:0] adr_q;
    logic        busy_q;
    logic        done_q;
    logic        en_q;
    logic [3:0]  data_q;

`ifdef MINIMAC2_TX_CRC_EN
    logic [31:0] crc_q;
    logic [31:0] crc_d;

    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int unsigned i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    always_comb begin
        crc_d = crc32_byte(crc_q, bus.txb_dat);
    end
`endif

    always_ff @(posedge phy_tx_clk or negedge phy_rst_n) begin
        if (!phy_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            hi_q    <= '0;
            adr_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            en_q    <= 1'b0;
            data_q  <= '0;
`ifdef MINIMAC2_TX_CRC_EN
            crc_q   <= '1;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // A start coinciding with the tx_done cycle is dropped.
                    if (bus.tx_start && !done_q) begin
                        if (bus.tx_count != '0) begin
                            rem_q   <= bus.tx_count;
                            adr_q   <= '0;
                            busy_q  <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= S_PREAMBLE;
`ifdef MINIMAC2_TX_CRC_EN
                            crc_q   <= '1;
`endif
                        end else begin
                            // Empty frame: jump to the last IFG cycle so that
                            // tx_done comes one edge later, busy never set.
                            cnt_q   <= IFG_LAST;
                            state_q <= S_IFG;
                        end
                    end
                end
                S_PREAMBLE: begin
                    en_q <= 1'b1;
                    if (cnt_q == PRE_LAST) begin
                        data_q  <= 4'hD;
                        state_q <= S_DATA_LO;
                    end else begin
                        data_q <= 4'h5;
                        cnt_q  <= cnt_q + 16'd1;
                    end
                end
                S_DATA_LO: begin
                    // Byte consumed now; its successor's address goes out so
                    // the sync RAM has it two edges later.
                    data_q  <= bus.txb_dat[3:0];
                    hi_q    <= bus.txb_dat[7:4];
                    adr_q   <= adr_q + 11'd1;
                    state_q <= S_DATA_HI;
`ifdef MINIMAC2_TX_CRC_EN
                    crc_q   <= crc_d;
`endif
                end
                S_DATA_HI: begin
                    data_q <= hi_q;
                    rem_q  <= rem_q - 11'd1;
                    if (rem_q == 11'd1) begin
                        cnt_q   <= '0;
`ifdef MINIMAC2_TX_CRC_EN
                        state_q <= S_FCS;
`else
                        state_q <= S_IFG;
`endif
                    end else begin
                        state_q <= S_DATA_LO;
                    end
                end
`ifdef MINIMAC2_TX_CRC_EN
                S_FCS: begin
                    data_q <= ~crc_q[3:0];
                    crc_q  <= crc_q >> 4;
                    if (cnt_q == 16'd7) begin
                        cnt_q   <= '0;
                        state_q <= S_IFG;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
`endif
                S_IFG: begin
                    en_q   <= 1'b0;
                    data_q <= '0;
                    if (cnt_q == IFG_LAST) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.tx_busy     = busy_q;
    assign bus.tx_done     = done_q;
    assign bus.txb_adr     = adr_q;
    assign bus.phy_tx_en   = en_q;
    assign bus.phy_tx_er   = 1'b0;
    assign bus.phy_tx_data = data_q;

endmodule
